// File: rtl/mor1kx_wb_arb_marocchino_if.sv
// Result-offer and write-back bundle between the MAROCCHINO execution units
// and the write-back arbiter.
interface mor1kx_wb_arb_marocchino_if #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_UNITS            = 4
);
    logic                                       pipeline_flush_i;
    logic                                       wb_stall_i;
    logic [NUM_UNITS-1:0]                       unit_valid_i;
    logic [NUM_UNITS*OPTION_OPERAND_WIDTH-1:0]  unit_result_i;
    logic [NUM_UNITS*OPTION_RF_ADDR_WIDTH-1:0]  unit_rfd_adr_i;
    logic [NUM_UNITS-1:0]                       unit_rf_wb_i;
    logic [NUM_UNITS-1:0]                       unit_except_i;
    logic [NUM_UNITS-1:0]                       unit_ready_o;
    logic                                       wb_valid_o;
    logic [OPTION_OPERAND_WIDTH-1:0]            wb_result_o;
    logic [OPTION_RF_ADDR_WIDTH-1:0]            wb_rfd_adr_o;
    logic                                       wb_rf_wb_o;
    logic                                       wb_except_o;
    logic [NUM_UNITS-1:0]                       wb_src_o;
    logic [15:0]                                wb_conflicts_o;

    modport master (
        output pipeline_flush_i, wb_stall_i, unit_valid_i, unit_result_i,
               unit_rfd_adr_i, unit_rf_wb_i, unit_except_i,
        input  unit_ready_o, wb_valid_o, wb_result_o, wb_rfd_adr_o,
               wb_rf_wb_o, wb_except_o, wb_src_o, wb_conflicts_o
    );

    modport slave (
        input  pipeline_flush_i, wb_stall_i, unit_valid_i, unit_result_i,
               unit_rfd_adr_i, unit_rf_wb_i, unit_except_i,
        output unit_ready_o, wb_valid_o, wb_result_o, wb_rfd_adr_o,
               wb_rf_wb_o, wb_except_o, wb_src_o, wb_conflicts_o
    );
endinterface

// File: rtl/mor1kx_wb_arb_marocchino.sv
// Write-back arbiter: picks one execution-unit result per cycle into the WB register.
// Define MOR1KX_WB_ARB_RR_EN for round-robin selection; default is fixed priority (unit 0 first).
module mor1kx_wb_arb_marocchino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_UNITS            = 4
) (
    input logic                        clk,
    input logic                        rst,
    mor1kx_wb_arb_marocchino_if.slave  wb_arb
);
    localparam int IDX_W = $clog2(NUM_UNITS);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                            vld_p1;
    logic [OPTION_OPERAND_WIDTH-1:0] result_p1;
    logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_p1;
    logic                            rf_wb_p1;
    logic                            except_p1;
    logic [NUM_UNITS-1:0]            src_p1;
    logic [15:0]                     conf_cnt_p1;

    logic                            accept;
    logic                            conflict;
    logic                            gnt_any;
    logic [IDX_W-1:0]                gnt_idx;
    logic [IDX_W-1:0]                rr_ptr;
    logic [NUM_UNITS-1:0]            gnt_p0;
    logic [OPTION_OPERAND_WIDTH-1:0] sel_result;
    logic [OPTION_RF_ADDR_WIDTH-1:0] sel_adr;
    logic                            sel_rf_wb;
    logic                            sel_except;

    // Stage p0: grant selection, combinational from offers and WB occupancy
    assign accept   = ~wb_arb.pipeline_flush_i & (~vld_p1 | ~wb_arb.wb_stall_i);
    assign conflict = ($countones(wb_arb.unit_valid_i) > 1);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_p0  = '0;
        cand    = 0;
        cidx    = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_UNITS;
            cidx = cand[IDX_W-1:0];
            if (accept && !gnt_any && wb_arb.unit_valid_i[cidx]) begin
                gnt_any = 1'b1;
                gnt_idx = cidx;
            end
        end
        if (gnt_any) gnt_p0[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_result = wb_arb.unit_result_i[int'(gnt_idx)*OPTION_OPERAND_WIDTH +: OPTION_OPERAND_WIDTH];
        sel_adr    = wb_arb.unit_rfd_adr_i[int'(gnt_idx)*OPTION_RF_ADDR_WIDTH +: OPTION_RF_ADDR_WIDTH];
        sel_rf_wb  = wb_arb.unit_rf_wb_i[gnt_idx];
        sel_except = wb_arb.unit_except_i[gnt_idx];
    end

`ifdef MOR1KX_WB_ARB_RR_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

    // Pointer moves only on an actual grant, so flush and stall leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rr_ptr <= '0;
        else if (gnt_any) rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
    end
`else
    assign rr_ptr = '0;
`endif

    // Stage p1: WB register and conflict statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            result_p1   <= '0;
            rfd_adr_p1  <= '0;
            rf_wb_p1    <= 1'b0;
            except_p1   <= 1'b0;
            src_p1      <= '0;
            conf_cnt_p1 <= '0;
        end else begin
            if (wb_arb.pipeline_flush_i) begin
                vld_p1    <= 1'b0;
                rf_wb_p1  <= 1'b0;
                except_p1 <= 1'b0;
                src_p1    <= '0;
            end else if (accept) begin
                if (gnt_any) begin
                    vld_p1     <= 1'b1;
                    result_p1  <= sel_result;
                    rfd_adr_p1 <= sel_adr;
                    rf_wb_p1   <= sel_rf_wb & ~sel_except;
                    except_p1  <= sel_except;
                    src_p1     <= gnt_p0;
                end else begin
                    // Result/address keep their last value on an empty slot.
                    vld_p1    <= 1'b0;
                    rf_wb_p1  <= 1'b0;
                    except_p1 <= 1'b0;
                    src_p1    <= '0;
                end
            end
            if (conflict && !wb_arb.pipeline_flush_i)
                conf_cnt_p1 <= sat_inc(conf_cnt_p1);
        end
    end

    assign wb_arb.unit_ready_o   = gnt_p0;
    assign wb_arb.wb_valid_o     = vld_p1;
    assign wb_arb.wb_result_o    = result_p1;
    assign wb_arb.wb_rfd_adr_o   = rfd_adr_p1;
    assign wb_arb.wb_rf_wb_o     = rf_wb_p1;
    assign wb_arb.wb_except_o    = except_p1;
    assign wb_arb.wb_src_o       = src_p1;
    assign wb_arb.wb_conflicts_o = conf_cnt_p1;
endmodule
